// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state type.
// Used by the read slave and the burst address generator.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RESP
  } state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats
  function automatic logic wrap_len_ok(
    input logic [7:0] len
  );
    return len inside {8'd1, 8'd3, 8'd7, 8'd15};
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Shared between the read and write channel slaves.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    size_i,
  input  logic [7:0]    len_i,
  input  logic [1:0]    burst_i,
  output logic [AW-1:0] next_o
);

  logic [AW-1:0] step;
  logic [AW-1:0] mask;
  logic [AW-1:0] incr;

  // Step to the next beat; wrap stays inside the burst-sized window
  always_comb begin
    step   = AW'(1) << size_i;
    mask   = ((AW'(len_i) + AW'(1)) << size_i) - AW'(1);
    incr   = addr_i + step;
    next_o = addr_i;
    unique case (burst_i)
      BURST_INCR:
        next_o = (addr_i & ~(step - AW'(1))) + step;
      BURST_WRAP:
        next_o = (addr_i & ~mask) | (incr & mask);
      default:
        next_o = addr_i;
    endcase
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI4 read responder: one burst at a time, one beat per
// FETCH/RESP pair from a single-cycle-latency backend.
module axi_read_slave
  import axi_pkg::*;
#(
  parameter int IDW = 12,
  parameter int AW  = 32,
  parameter int DW  = 64
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic [IDW-1:0] s_axi_arid,
  input  logic [AW-1:0]  s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,
  output logic [IDW-1:0] s_axi_rid,
  output logic [DW-1:0]  s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready,
  output logic           mem_en,
  output logic [AW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  input  logic           mem_err
);

  localparam int MAXSZ = $clog2(DW / 8);

  state_e         state_q, state_d;
  logic           arready_q, arready_d;
  logic [IDW-1:0] id_q, id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [7:0]     len_q, len_d;
  logic [2:0]     size_q, size_d;
  logic [1:0]     burst_q, burst_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           first_q, first_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [1:0]     rresp_q, rresp_d;

  logic [AW-1:0]  next_addr;
  logic           ar_err;
  logic [DW-1:0]  beat_data;
  logic [1:0]     beat_resp;

  axi_burst_addr_gen #(
    .AW (AW)
  ) u_addr_gen (
    .addr_i  (addr_q),
    .size_i  (size_q),
    .len_i   (len_q),
    .burst_i (burst_q),
    .next_o  (next_addr)
  );

  // Illegal size, reserved burst or bad wrap length
  always_comb begin
    ar_err = (s_axi_arsize > 3'(MAXSZ))
          || (s_axi_arburst == BURST_RSVD)
          || ((s_axi_arburst == BURST_WRAP)
              && !wrap_len_ok(s_axi_arlen));
  end

  // Backend data arrives in the first RESP cycle; held after
  always_comb begin
    beat_data = err_q ? '0 : mem_rdata;
    beat_resp = (err_q || mem_err) ? RESP_SLVERR
                                   : RESP_OKAY;
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    first_d   = 1'b0;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (first_q) begin
      rdata_d = beat_data;
      rresp_d = beat_resp;
    end
    unique case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          len_d     = s_axi_arlen;
          size_d    = s_axi_arsize;
          burst_d   = s_axi_arburst;
          cnt_d     = s_axi_arlen;
          err_d     = ar_err;
          arready_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        first_d = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (s_axi_rready) begin
          if (cnt_q == 8'd0) begin
            arready_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d   = cnt_q - 8'd1;
            addr_d  = next_addr;
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        arready_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      first_q   <= first_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Port outputs
  always_comb begin
    s_axi_arready = arready_q;
    s_axi_rvalid  = (state_q == ST_RESP);
    s_axi_rlast   = (state_q == ST_RESP)
                 && (cnt_q == 8'd0);
    s_axi_rid     = id_q;
    s_axi_rdata   = first_q ? beat_data : rdata_q;
    s_axi_rresp   = first_q ? beat_resp : rresp_q;
    mem_en        = (state_q == ST_FETCH) && !err_q;
    mem_addr      = addr_q;
  end

endmodule

// File: tb/tb_axi_read_slave.sv
// Randomised self-checking bench for axi_read_slave against
// an address-list / backend-memory reference model.
module tb_axi_read_slave;

  localparam int IDW = 12;
  localparam int AW  = 32;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic [IDW-1:0] s_axi_arid = '0;
  logic [AW-1:0]  s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic [2:0]     s_axi_arsize = '0;
  logic [1:0]     s_axi_arburst = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [IDW-1:0] s_axi_rid;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic           mem_en;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata = '0;
  logic           mem_err = 1'b0;

  int total = 0;
  int bad = 0;

  logic [AW-1:0] fetch_log[$];
  logic [AW-1:0] exp_a[$];
  logic          err_on = 1'b0;
  logic [AW-1:0] err_addr = '0;

  always #5 clk = ~clk;

  axi_read_slave #(
    .IDW (IDW),
    .AW  (AW),
    .DW  (DW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_arid    (s_axi_arid),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_err       (mem_err)
  );

  function automatic logic [DW-1:0] dgen(
    input logic [AW-1:0] a
  );
    return {a ^ 32'hA5A5_0F0F, ~a};
  endfunction

  // Synchronous backend: data valid the cycle after mem_en
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= dgen(mem_addr);
      mem_err   <= err_on && (mem_addr == err_addr);
      fetch_log.push_back(mem_addr);
    end
  end

  function automatic bit burst_err(
    input int len, input int size, input int burst
  );
    return (size > 3) || (burst == 3)
        || (burst == 2 && !(len == 1 || len == 3
                            || len == 7 || len == 15));
  endfunction

  // Expected beat addresses from the burst rules
  task automatic build_model(
    input logic [AW-1:0] a0, input int len,
    input int size, input int burst
  );
    longint unsigned a, sz, blk, base;
    exp_a.delete();
    a  = a0;
    sz = 64'd1 << size;
    for (int b = 0; b <= len; b++) begin
      exp_a.push_back(a[31:0]);
      if (burst == 1) begin
        a = (a / sz) * sz + sz;
      end else if (burst == 2) begin
        blk  = longint'(len + 1) * sz;
        base = (a / blk) * blk;
        a    = base + ((a + sz) % blk);
      end
      a = a % 64'h1_0000_0000;
    end
  endtask

  // One full burst; mode 0 accept, 1 stall once, 2 random
  task automatic do_read(
    input logic [IDW-1:0] id, input logic [AW-1:0] addr,
    input int len, input int size, input int burst,
    input int mode, input string tag
  );
    bit e;
    int k, n;
    logic [DW-1:0] ed;
    logic [1:0] er;
    logic el;
    e = burst_err(len, size, burst);
    build_model(addr, len, size, burst);
    @(negedge clk);
    fetch_log.delete();
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = 8'(len);
    s_axi_arsize  = 3'(size);
    s_axi_arburst = 2'(burst);
    s_axi_arvalid = 1'b1;
    k = 0;
    while (!s_axi_arready && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (s_axi_arready !== 1'b1) begin
      bad++;
      $display("FAIL %s arready timeout", tag);
      s_axi_arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
    @(negedge clk);
    total++;
    if (s_axi_rvalid !== 1'b0 || mem_en !== !e
        || (!e && mem_addr !== exp_a[0])) begin
      bad++;
      $display("FAIL %s fetch0: rvalid=%b mem_en=%b addr=%h exp en=%b addr=%h",
               tag, s_axi_rvalid, mem_en, mem_addr, !e, exp_a[0]);
    end
    @(negedge clk);
    for (int b = 0; b <= len; b++) begin
      total++;
      if (s_axi_rvalid !== 1'b1) begin
        bad++;
        $display("FAIL %s beat%0d rvalid=%b exp 1",
                 tag, b, s_axi_rvalid);
        return;
      end
      ed = e ? '0 : dgen(exp_a[b]);
      er = (e || (err_on && exp_a[b] == err_addr))
         ? 2'b10 : 2'b00;
      el = (b == len);
      n = (mode == 1) ? 1
        : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s <= n; s++) begin
        if (s > 0) total++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rid !== id
            || s_axi_rdata !== ed || s_axi_rresp !== er
            || s_axi_rlast !== el || s_axi_arready !== 1'b0) begin
          bad++;
          $display("FAIL %s beat%0d stall%0d: v=%b id=%h d=%h r=%b l=%b ar=%b exp v=1 id=%h d=%h r=%b l=%b ar=0",
                   tag, b, s, s_axi_rvalid, s_axi_rid, s_axi_rdata,
                   s_axi_rresp, s_axi_rlast, s_axi_arready,
                   id, ed, er, el);
        end
        s_axi_rready = (s == n);
        @(negedge clk);
      end
      s_axi_rready = 1'b0;
      total++;
      if (b < len) begin
        if (s_axi_rvalid !== 1'b0 || mem_en !== !e
            || (!e && mem_addr !== exp_a[b+1])
            || s_axi_arready !== 1'b0) begin
          bad++;
          $display("FAIL %s fetch%0d: v=%b en=%b addr=%h exp en=%b addr=%h",
                   tag, b + 1, s_axi_rvalid, mem_en, mem_addr,
                   !e, exp_a[b+1]);
        end
        @(negedge clk);
      end else begin
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
          bad++;
          $display("FAIL %s end: arready=%b rvalid=%b exp 1 0",
                   tag, s_axi_arready, s_axi_rvalid);
        end
      end
    end
    total++;
    if (fetch_log.size() != (e ? 0 : len + 1)) begin
      bad++;
      $display("FAIL %s fetch count=%0d exp %0d",
               tag, fetch_log.size(), e ? 0 : len + 1);
    end else begin
      for (int i = 0; i < fetch_log.size(); i++) begin
        if (fetch_log[i] !== exp_a[i]) begin
          bad++;
          $display("FAIL %s fetch log[%0d]=%h exp %h",
                   tag, i, fetch_log[i], exp_a[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (s_axi_arready !== 1'b0 || s_axi_rvalid !== 1'b0
        || s_axi_rlast !== 1'b0 || s_axi_rresp !== 2'b00
        || s_axi_rid !== '0 || s_axi_rdata !== '0
        || mem_en !== 1'b0 || mem_addr !== '0) begin
      bad++;
      $display("FAIL reset values: ar=%b v=%b l=%b r=%b id=%h d=%h en=%b a=%h exp all 0",
               s_axi_arready, s_axi_rvalid, s_axi_rlast,
               s_axi_rresp, s_axi_rid, s_axi_rdata,
               mem_en, mem_addr);
    end
    resetn = 1'b1;
    #1;
    total++;
    if (s_axi_arready !== 1'b0) begin
      bad++;
      $display("FAIL reset release arready=%b exp 0",
               s_axi_arready);
    end
    @(negedge clk);
    total++;
    if (s_axi_arready !== 1'b1) begin
      bad++;
      $display("FAIL reset rise arready=%b exp 1",
               s_axi_arready);
    end
  endtask

  task automatic test_incr();
    do_read(12'h123, 32'h100, 3, 3, 1, 0, "incr");
    do_read(12'h045, 32'h103, 4, 2, 1, 2, "incr_unal");
  endtask

  task automatic test_wrap();
    do_read(12'h321, 32'h38, 3, 3, 2, 0, "wrap");
    do_read(12'h00F, 32'h1E, 7, 1, 2, 2, "wrap8");
  endtask

  task automatic test_fixed_stall();
    do_read(12'h7AA, 32'h40, 2, 3, 0, 1, "fixed");
  endtask

  task automatic test_burst_err();
    do_read(12'h111, 32'h80, 2, 4, 1, 0, "err_size");
    do_read(12'h222, 32'h80, 2, 3, 2, 1, "err_wrap");
    do_read(12'h333, 32'h80, 1, 2, 3, 0, "err_rsvd");
  endtask

  task automatic test_mem_err();
    err_on   = 1'b1;
    err_addr = 32'h210;
    do_read(12'hABC, 32'h200, 3, 3, 1, 0, "mem_err");
    err_on   = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    s_axi_arid    = 12'h5A5;
    s_axi_araddr  = 32'h300;
    s_axi_arlen   = 8'd7;
    s_axi_arsize  = 3'd3;
    s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    k = 0;
    while (!s_axi_arready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 s_axi_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (s_axi_rvalid !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid beat1 rvalid=%b exp 1",
               s_axi_rvalid);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0
        || mem_en !== 1'b0 || s_axi_rdata !== '0
        || s_axi_rid !== '0 || s_axi_rlast !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid async: v=%b ar=%b en=%b d=%h id=%h l=%b exp all 0",
               s_axi_rvalid, s_axi_arready, mem_en,
               s_axi_rdata, s_axi_rid, s_axi_rlast);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid release: ar=%b v=%b exp 1 0",
               s_axi_arready, s_axi_rvalid);
    end
    do_read(12'h0C3, 32'h508, 0, 3, 1, 0, "post_rst");
  endtask

  task automatic test_random();
    int len, size, burst;
    for (int i = 0; i < 30; i++) begin
      burst = $urandom_range(0, 3);
      if (burst == 2 && ($urandom % 4) != 0)
        len = (2 << $urandom_range(0, 3)) - 1;
      else
        len = $urandom_range(0, 15);
      size = (($urandom % 8) == 0) ? 4 : $urandom_range(0, 3);
      do_read(IDW'($urandom), $urandom, len, size,
              burst, 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_burst_err();
    test_mem_err();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_read_slave.md
# axi_read_slave

AXI4 read-channel responder (AR/R): accepts one read-address request at a time, walks the burst address sequence, fetches each beat from a single-cycle-latency backend memory port and returns R beats with correct RID/RRESP/RLAST. It is the read-direction counterpart of the write-channel slave and sits between an AXI read master and an on-chip RAM or register file. Bursts are serialised: no outstanding-transaction queue, no read interleaving.

## Interface
Parameters:
- IDW, 12, ID width
- AW, 32, address width
- DW, 64, data width in bits; power of two, ≥ 8

Ports:
- clk  in  1  single clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset; one clock; async assert, clears all state immediately
- s_axi_arid  in  IDW  request ID
- s_axi_araddr  in  AW  start byte address
- s_axi_arlen  in  8  beats − 1
- s_axi_arsize  in  3  log2 bytes per beat
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_arvalid  in  1  address valid
- s_axi_arready  out  1  address ready
- s_axi_rid  out  IDW  response ID
- s_axi_rdata  out  DW  read data
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s_axi_rlast  out  1  final beat
- s_axi_rvalid  out  1  data valid
- s_axi_rready  in  1  master accepts data
- mem_en  out  1  backend read strobe
- mem_addr  out  AW  backend byte address (current beat address)
- mem_rdata  in  DW  backend data, valid the cycle after mem_en
- mem_err  in  1  backend error, valid with mem_rdata

## Operation
- States: IDLE, FETCH, RESP.
- IDLE: arready=1. On arvalid&&arready: capture arid, araddr, arlen, arsize, arburst; beat counter ← arlen; compute burst error flag; → FETCH.
- Burst error if any of: arsize > log2(DW/8); arburst=11; arburst=WRAP with arlen ∉ {1,3,7,15}.
- FETCH (1 cycle): mem_en=1 and mem_addr=current address unless burst error; → RESP.
- RESP: rvalid=1. rdata ← mem_rdata captured at FETCH→RESP edge (0 when burst error); rresp=SLVERR if burst error or mem_err, else OKAY; rlast=(counter==0); rid=captured arid. All R outputs held stable while rvalid&&!rready.
- On rvalid&&rready: if rlast → IDLE; else counter−1, address ← next address, → FETCH.
- Next address, size=1<<arsize: FIXED unchanged; INCR (addr & ~(size−1)) + size; WRAP mask=(arlen+1)·size−1, next=(addr & ~mask) | ((addr+size) & mask). First beat uses unaligned araddr as given. Arithmetic modulo 2^AW; no 4 KB boundary check.
- Data is not lane-shifted; mem_rdata passes through as full DW bus.

## Timing
- Reset values: arready=0, rvalid=0, rlast=0, rresp=00, rid=0, rdata=0, mem_en=0, mem_addr=0; state=IDLE. arready rises on first clk edge after resetn deasserts.
- AR handshake at edge N → mem_en high in cycle N+1 → rvalid high in cycle N+2.
- R handshake (non-last) at edge M → mem_en in M+1 → next rvalid in M+2. Peak throughput one beat per 2 cycles.
- Last-beat handshake at edge M → arready high in cycle M+1; arready low in FETCH and RESP.
- rvalid never deasserts without handshake (except reset).
- Reset mid-burst: all outputs to reset values asynchronously; burst abandoned, no completion.
- arvalid while busy: ignored (arready=0); request held by master.

## Structure
- Shared package axi_pkg: burst encodings (FIXED/INCR/WRAP), resp encodings (OKAY/SLVERR), state enum {IDLE, FETCH, RESP}.
- One sub-module: axi_burst_addr_gen (combinational next-address from addr, size, len, burst); reused later by the write side.

## Test plan
- INCR araddr=0x100, arlen=3, arsize=3, rready=1 → mem_addr 0x100,0x108,0x110,0x118; 4 OKAY beats, rlast on 4th; rvalid first at cycle N+2.
- WRAP araddr=0x38, arlen=3, arsize=3 → mem_addr 0x38,0x20,0x28,0x30.
- FIXED araddr=0x40, arlen=2, rready toggled 1/0 → mem_addr 0x40 ×3; rdata/rlast stable during rready=0 stalls.
- arsize=4 with DW=64 (or WRAP arlen=2) → arlen+1 beats SLVERR, rdata=0, mem_en never asserted, rlast on final beat.
- mem_err=1 on beat 2 of INCR arlen=3 → beat 2 SLVERR, others OKAY; arid=0xABC returned on all beats.
- resetn pulled low during beat 1 of arlen=7 → rvalid=0 immediately; after release arready=1 next cycle and a new arlen=0 read completes normally.
